uart_io_port: RTL

Buffered, memory-mapped UART front end: sits between the processor bus decode and the `uart` core, replacing the single-register strobe glue with parametrised TX and RX FIFOs, a status register carrying levels and sticky error flags, and a drain engine that feeds the core autonomously. The system address decoder drives `sel_i` for the UART window (0x2000–0x2FFF); this block decodes word offsets within it.

---
 rtl/uart_io_port.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/uart_io_port.sv
// uart_io_port: buffered memory-mapped UART front end with TX/RX FIFOs, status/control registers
// and autonomous drain/capture FSMs. Define UART_IO_PORT_IRQ_EN to add the registered irq_o output.
//
// state      | meaning
// TX_IDLE    | waiting for a queued byte and an idle core
// TX_LAUNCH  | uart_wr_o strobe cycle
// TX_WAIT_HI | waiting for core busy to rise, 4-cycle timeout
// TX_WAIT_LO | waiting for core busy to fall
// RX_IDLE    | waiting for uart_valid_i
// RX_ACK     | uart_rd_o strobe cycle
// RX_GUARD   | uart_valid_i ignored while the core retires the byte
module uart_io_port #(
    parameter int TX_DEPTH  = 16,
    parameter int RX_DEPTH  = 16,
    parameter int BUS_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset_i,
    input  logic                 sel_i,
    input  logic [3:0]           addr_i,
    input  logic                 we_i,
    input  logic                 re_i,
    input  logic [BUS_WIDTH-1:0] data_in_i,
    output logic [BUS_WIDTH-1:0] data_out_o,
    output logic                 uart_wr_o,
    output logic [7:0]           uart_tx_data_o,
    input  logic                 uart_busy_i,
    output logic                 uart_rd_o,
    input  logic [7:0]           uart_rx_data_i,
    input  logic                 uart_valid_i
`ifdef UART_IO_PORT_IRQ_EN
    ,
    output logic                 irq_o
`endif
);

    localparam int TX_AW = $clog2(TX_DEPTH);
    localparam int RX_AW = $clog2(RX_DEPTH);
    localparam int TX_CW = TX_AW + 1;
    localparam int RX_CW = RX_AW + 1;

    typedef enum logic [1:0] {TX_IDLE, TX_LAUNCH, TX_WAIT_HI, TX_WAIT_LO} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_ACK, RX_GUARD} rx_state_t;

    tx_state_t        tx_state_q, tx_state_d;
    rx_state_t        rx_state_q, rx_state_d;
    logic [1:0]       tx_timer_q, tx_timer_d;
    logic [7:0]       tx_mem_q [TX_DEPTH];
    logic [7:0]       rx_mem_q [RX_DEPTH];
    logic [TX_AW-1:0] tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
    logic [RX_AW-1:0] rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
    logic [TX_CW-1:0] tx_count_q, tx_count_d;
    logic [RX_CW-1:0] rx_count_q, rx_count_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic             rx_ovr_q, rx_ovr_d, tx_ovf_q, tx_ovf_d;
    logic [1:0]       en_bits;
    logic [1:0]       word;
    logic             data_wr, data_rd, ctrl_wr, tx_flush, rx_flush;
    logic             tx_full, tx_empty, rx_full, rx_nempty;
    logic             tx_push, tx_pop, tx_drop, rx_cap, rx_push, rx_pop, rx_drop;
    logic             unused_bits;

    assign word     = addr_i[3:2];
    assign data_wr  = sel_i & we_i & (word == 2'd0);
    assign data_rd  = sel_i & re_i & (word == 2'd0);
    assign ctrl_wr  = sel_i & we_i & (word == 2'd2);
    assign tx_flush = ctrl_wr & data_in_i[2];
    assign rx_flush = ctrl_wr & data_in_i[3];

    assign tx_full   = (tx_count_q == TX_CW'(TX_DEPTH));
    assign tx_empty  = (tx_count_q == '0);
    assign rx_full   = (rx_count_q == RX_CW'(RX_DEPTH));
    assign rx_nempty = (rx_count_q != '0);

    // A full FIFO still accepts a push when the same cycle pops it.
    assign tx_pop  = (tx_state_q == TX_IDLE) & ~tx_empty & ~uart_busy_i;
    assign tx_push = data_wr & (~tx_full | tx_pop) & ~tx_flush;
    assign tx_drop = data_wr & tx_full & ~tx_pop;
    assign rx_pop  = data_rd & rx_nempty;
    assign rx_cap  = (rx_state_q == RX_IDLE) & uart_valid_i;
    assign rx_push = rx_cap & (~rx_full | rx_pop) & ~rx_flush;
    assign rx_drop = rx_cap & rx_full & ~rx_pop;

    assign unused_bits = ^{addr_i[1:0], data_in_i};

    always_comb begin
        tx_wptr_d  = tx_wptr_q;
        tx_rptr_d  = tx_rptr_q;
        tx_count_d = tx_count_q;
        if (tx_flush) begin
            tx_wptr_d  = '0;
            tx_rptr_d  = '0;
            tx_count_d = '0;
        end else begin
            if (tx_push) tx_wptr_d = tx_wptr_q + TX_AW'(1);
            if (tx_pop)  tx_rptr_d = tx_rptr_q + TX_AW'(1);
            if (tx_push && !tx_pop)      tx_count_d = tx_count_q + TX_CW'(1);
            else if (!tx_push && tx_pop) tx_count_d = tx_count_q - TX_CW'(1);
        end
    end

    always_comb begin
        rx_wptr_d  = rx_wptr_q;
        rx_rptr_d  = rx_rptr_q;
        rx_count_d = rx_count_q;
        if (rx_flush) begin
            rx_wptr_d  = '0;
            rx_rptr_d  = '0;
            rx_count_d = '0;
        end else begin
            if (rx_push) rx_wptr_d = rx_wptr_q + RX_AW'(1);
            if (rx_pop)  rx_rptr_d = rx_rptr_q + RX_AW'(1);
            if (rx_push && !rx_pop)      rx_count_d = rx_count_q + RX_CW'(1);
            else if (!rx_push && rx_pop) rx_count_d = rx_count_q - RX_CW'(1);
        end
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_timer_d = tx_timer_q;
        tx_data_d  = tx_pop ? tx_mem_q[tx_rptr_q] : tx_data_q;
        case (tx_state_q)
            TX_IDLE:    if (tx_pop) tx_state_d = TX_LAUNCH;
            TX_LAUNCH: begin
                tx_state_d = TX_WAIT_HI;
                tx_timer_d = 2'd3;
            end
            TX_WAIT_HI: begin
                if (uart_busy_i)              tx_state_d = TX_WAIT_LO;
                else if (tx_timer_q == 2'd0)  tx_state_d = TX_IDLE;
                else                          tx_timer_d = tx_timer_q - 2'd1;
            end
            TX_WAIT_LO: if (!uart_busy_i) tx_state_d = TX_IDLE;
            default:    tx_state_d = TX_IDLE;
        endcase
    end

    always_comb begin
        rx_state_d = rx_state_q;
        case (rx_state_q)
            RX_IDLE:  if (uart_valid_i) rx_state_d = RX_ACK;
            RX_ACK:   rx_state_d = RX_GUARD;
            RX_GUARD: rx_state_d = RX_IDLE;
            default:  rx_state_d = RX_IDLE;
        endcase
    end

    // Sticky flags: a set in the same cycle as a clear wins.
    always_comb begin
        rx_ovr_d = rx_drop | (rx_ovr_q & ~(ctrl_wr & data_in_i[0]));
        tx_ovf_d = tx_drop | (tx_ovf_q & ~(ctrl_wr & data_in_i[1]));
    end

    always_ff @(posedge clk) begin
        if (reset_i) begin
            tx_state_q <= TX_IDLE;
            rx_state_q <= RX_IDLE;
            tx_timer_q <= '0;
            tx_wptr_q  <= '0;
            tx_rptr_q  <= '0;
            rx_wptr_q  <= '0;
            rx_rptr_q  <= '0;
            tx_count_q <= '0;
            rx_count_q <= '0;
            tx_data_q  <= '0;
            rx_ovr_q   <= 1'b0;
            tx_ovf_q   <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            rx_state_q <= rx_state_d;
            tx_timer_q <= tx_timer_d;
            tx_wptr_q  <= tx_wptr_d;
            tx_rptr_q  <= tx_rptr_d;
            rx_wptr_q  <= rx_wptr_d;
            rx_rptr_q  <= rx_rptr_d;
            tx_count_q <= tx_count_d;
            rx_count_q <= rx_count_d;
            tx_data_q  <= tx_data_d;
            rx_ovr_q   <= rx_ovr_d;
            tx_ovf_q   <= tx_ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem_q[tx_wptr_q] <= data_in_i[7:0];
        if (rx_push) rx_mem_q[rx_wptr_q] <= uart_rx_data_i;
    end

`ifdef UART_IO_PORT_IRQ_EN
    logic [1:0] en_q, en_d;
    logic       irq_q, irq_d;

    always_comb begin
        en_d  = ctrl_wr ? data_in_i[5:4] : en_q;
        irq_d = (en_q[0] & rx_nempty) | (en_q[1] & tx_empty);
    end

    always_ff @(posedge clk) begin
        if (reset_i) begin
            en_q  <= 2'b00;
            irq_q <= 1'b0;
        end else begin
            en_q  <= en_d;
            irq_q <= irq_d;
        end
    end

    assign en_bits = en_q;
    assign irq_o   = irq_q;
`else
    assign en_bits = 2'b00;
`endif

    assign uart_wr_o      = (tx_state_q == TX_LAUNCH);
    assign uart_rd_o      = (rx_state_q == RX_ACK);
    assign uart_tx_data_o = tx_data_q;

    always_comb begin
        data_out_o = '0;
        case (word)
            2'd0: if (rx_nempty) data_out_o[7:0] = rx_mem_q[rx_rptr_q];
            2'd1: data_out_o[23:0] = {8'(tx_count_q), 8'(rx_count_q), 3'b000,
                                      tx_ovf_q, rx_ovr_q, tx_empty, rx_nempty, tx_full};
            2'd2: data_out_o[5:4] = en_bits;
            default: ;
        endcase
    end

endmodule
